store_buffer: RTL

// - Write-side companion to the data memory load path: accepts SB/SH/SW requests from the core.
// - Formats each request into a word-aligned address, lane-replicated data and a 4-bit byte mask.
// - Queues requests in a DEPTH-entry FIFO and drains them one per cycle to the memory write port.
// - Flags loads that hit a word still pending in the queue, so the core stalls the load.

---
 rtl/store_buffer.sv | 135 +++++++++++++
 1 files changed

// File: rtl/store_buffer.sv
// Store buffer: formats SB/SH/SW requests into word-aligned, lane-replicated, byte-masked
// entries, queues them in a FIFO, drains one per cycle and flags loads to pending words.
module store_buffer #(
  parameter int unsigned DM_ADDRESS = 9,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     st_valid,
  output logic                     st_ready,
  input  logic [DM_ADDRESS-1:0]    st_addr,
  input  logic [DATA_W-1:0]        st_data,
  input  logic [2:0]               st_funct3,
  output logic                     st_misalign,
  output logic                     mem_wr_en,
  input  logic                     mem_ready,
  output logic [DM_ADDRESS-1:0]    mem_waddr,
  output logic [DATA_W-1:0]        mem_wdata,
  output logic [3:0]               mem_wmask,
  input  logic                     ld_valid,
  input  logic [DM_ADDRESS-1:0]    ld_addr,
  output logic                     ld_hazard,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [DM_ADDRESS-1:0] waddr_q [DEPTH];
  logic [DM_ADDRESS-1:0] waddr_d [DEPTH];
  logic [DATA_W-1:0]     wdata_q [DEPTH];
  logic [DATA_W-1:0]     wdata_d [DEPTH];
  logic [3:0]            wmask_q [DEPTH];
  logic [3:0]            wmask_d [DEPTH];
  logic [DEPTH-1:0]      valid_q, valid_d;
  logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]       count_q, count_d;
  logic                  misalign_q, misalign_d;

  logic              fmt_ok;
  logic [3:0]        fmt_mask;
  logic [DATA_W-1:0] fmt_data;
  logic              enq, deq, ld_hit;

  always_comb begin
    fmt_ok   = 1'b0;
    fmt_mask = 4'b0000;
    fmt_data = st_data;
    case (st_funct3)
      3'b000: begin
        fmt_ok   = 1'b1;
        fmt_mask = 4'b0001 << st_addr[1:0];
        fmt_data = {4{st_data[7:0]}};
      end
      3'b001: begin
        fmt_ok   = ~st_addr[0];
        fmt_mask = st_addr[1] ? 4'b1100 : 4'b0011;
        fmt_data = {2{st_data[15:0]}};
      end
      3'b010: begin
        fmt_ok   = (st_addr[1:0] == 2'b00);
        fmt_mask = 4'b1111;
        fmt_data = st_data;
      end
      default: fmt_ok = 1'b0;
    endcase
  end

  assign full      = (count_q == CntW'(DEPTH));
  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign st_ready  = ~full;
  assign mem_wr_en = ~empty;
  assign mem_waddr = waddr_q[rd_ptr_q];
  assign mem_wdata = wdata_q[rd_ptr_q];
  assign mem_wmask = wmask_q[rd_ptr_q];
  assign st_misalign = misalign_q;

  assign enq = st_valid & st_ready & fmt_ok;
  assign deq = mem_wr_en & mem_ready;
  assign misalign_d = st_valid & st_ready & ~fmt_ok;

  always_comb begin
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    wmask_d = wmask_q;
    valid_d = valid_q;
    if (deq) valid_d[rd_ptr_q] = 1'b0;
    // Enqueue and dequeue never share a slot: that would need count 0 (no deq) or full (no enq).
    if (enq) begin
      valid_d[wr_ptr_q] = 1'b1;
      waddr_d[wr_ptr_q] = {st_addr[DM_ADDRESS-1:2], 2'b00};
      wdata_d[wr_ptr_q] = fmt_data;
      wmask_d[wr_ptr_q] = fmt_mask;
    end
    wr_ptr_d = wr_ptr_q + PtrW'(enq);
    rd_ptr_d = rd_ptr_q + PtrW'(deq);
    count_d  = count_q + CntW'(enq) - CntW'(deq);
  end

  // Entries leaving this cycle still block loads; entries arriving this cycle do not.
  always_comb begin
    ld_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (waddr_q[i][DM_ADDRESS-1:2] == ld_addr[DM_ADDRESS-1:2])) ld_hit = 1'b1;
    end
  end
  assign ld_hazard = ld_valid & ld_hit;

  always_ff @(posedge clk) begin
    if (reset) begin
      waddr_q    <= '{default: '0};
      wdata_q    <= '{default: '0};
      wmask_q    <= '{default: '0};
      valid_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      misalign_q <= 1'b0;
    end else begin
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      wmask_q    <= wmask_d;
      valid_q    <= valid_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      misalign_q <= misalign_d;
    end
  end

endmodule
